// File: rtl/arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl.sv
// Regional clock-block power controller.
// It sequences the regional power enable (RPEn) around array activity and waits
// a fixed settle time before ActRdy. An idle-hold window keeps the clock running
// across short gaps in activity. LCP bits are frozen whenever the clock is on.
//
// Ports
//   CkGridX1N  in   grid clock; every state update is on its rising edge
//   Rst        in   synchronous active-high reset
//   ActReq     in   activity request from array control
//   IdleHold   in   idle cycles to keep the clock running after ActReq drops
//   OvrdCfg    in   software power override request
//   LcpCfg     in   LCP configuration {Fd,Rd}
//   RPEn       out  regional power enable (1 = functional)
//   RPOvrd     out  regional power override (OvrdCfg delayed one cycle)
//   Fd, Rd     out  LCP bits, loaded only while idle
//   ActRdy     out  clock running and settled
//   St         out  FSM state for debug (IDLE=00 WAKE=01 ACTIVE=10 HOLD=11)
module arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl #(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic              CkGridX1N,
    input  logic              Rst,
    input  logic              ActReq,
    input  logic [HOLD_W-1:0] IdleHold,
    input  logic              OvrdCfg,
    input  logic [1:0]        LcpCfg,
    output logic              RPEn,
    output logic              RPOvrd,
    output logic              Fd,
    output logic              Rd,
    output logic              ActRdy,
    output logic [1:0]        St
);

    // WAKE_CYC is limited to 1..15, so four bits hold any legal settle count
    localparam int unsigned WAKE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAKE   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    state_e            st_q, st_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        lcp_q, lcp_d;
    logic              rpen_q, actrdy_q, ovrd_q;

    // Next-state and counter logic
    always_comb begin
        st_d       = st_q;
        wake_cnt_d = wake_cnt_q;
        hold_cnt_d = hold_cnt_q;
        // LCP only tracks the config while idle; the IDLE-cycle load is the last one
        lcp_d      = (st_q == ST_IDLE) ? LcpCfg : lcp_q;

        case (st_q)
            ST_IDLE: begin
                if (ActReq) begin
                    // With override already active the clock is running: skip settle
                    if (ovrd_q) begin
                        st_d = ST_ACTIVE;
                    end else begin
                        st_d       = ST_WAKE;
                        wake_cnt_d = WAKE_W'(WAKE_CYC);
                    end
                end
            end
            ST_WAKE: begin
                // Wake always completes; ActReq is not looked at until ACTIVE
                if (wake_cnt_q <= WAKE_W'(1)) begin
                    st_d = ST_ACTIVE;
                end
                if (wake_cnt_q != '0) begin
                    wake_cnt_d = wake_cnt_q - WAKE_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!ActReq) begin
                    if (IdleHold == '0) begin
                        st_d = ST_IDLE;
                    end else begin
                        st_d       = ST_HOLD;
                        hold_cnt_d = IdleHold;
                    end
                end
            end
            ST_HOLD: begin
                if (ActReq) begin
                    st_d = ST_ACTIVE;
                end else begin
                    if (hold_cnt_q <= HOLD_W'(1)) begin
                        st_d = ST_IDLE;
                    end
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CkGridX1N) begin
        if (Rst) begin
            st_q       <= ST_IDLE;
            wake_cnt_q <= '0;
            hold_cnt_q <= '0;
            lcp_q      <= '0;
            rpen_q     <= 1'b0;
            actrdy_q   <= 1'b0;
            ovrd_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            wake_cnt_q <= wake_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            lcp_q      <= lcp_d;
            rpen_q     <= (st_d != ST_IDLE);
            actrdy_q   <= (st_d == ST_ACTIVE) || (st_d == ST_HOLD);
            ovrd_q     <= OvrdCfg;
        end
    end

    assign St     = st_q;
    assign RPEn   = rpen_q;
    assign ActRdy = actrdy_q;
    assign RPOvrd = ovrd_q;
    assign Fd     = lcp_q[1];
    assign Rd     = lcp_q[0];

endmodule

// File: tb/tb_arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl.sv
// Self-checking bench for the regional clock-block power controller.
// A cycle model pushes the expected output vector {St,RPEn,ActRdy,RPOvrd,Fd,Rd}
// into a scoreboard every time a cycle is driven; each scenario task drains it
// against the captured DUT outputs and also checks fixed expected values.
module tb_arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl;

    localparam int unsigned WAKE_CYC = 2;
    localparam int unsigned HOLD_W   = 4;

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_WAKE = 2'b01;
    localparam logic [1:0] M_ACT  = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              act_req;
    logic [HOLD_W-1:0] idle_hold;
    logic              ovrd_cfg;
    logic [1:0]        lcp_cfg;
    logic              rpen, rpovrd, fd, rd, act_rdy;
    logic [1:0]        st;

    always #5 clk = ~clk;

    arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl #(
        .WAKE_CYC (WAKE_CYC),
        .HOLD_W   (HOLD_W)
    ) dut (
        .CkGridX1N (clk),
        .Rst       (rst),
        .ActReq    (act_req),
        .IdleHold  (idle_hold),
        .OvrdCfg   (ovrd_cfg),
        .LcpCfg    (lcp_cfg),
        .RPEn      (rpen),
        .RPOvrd    (rpovrd),
        .Fd        (fd),
        .Rd        (rd),
        .ActRdy    (act_rdy),
        .St        (st)
    );

    logic [6:0] sb_q[$];
    logic [6:0] obs_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference model state
    logic [1:0] m_st   = M_IDLE;
    int         m_wc   = 0;
    int         m_hc   = 0;
    logic       m_ovrd = 1'b0;
    logic [1:0] m_lcp  = 2'b00;

    function automatic logic [6:0] dut_obs();
        return {st, rpen, act_rdy, rpovrd, fd, rd};
    endfunction

    function automatic logic [6:0] model_obs();
        return {m_st, (m_st != M_IDLE), m_st[1], m_ovrd, m_lcp};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [1:0] nst;
        if (rst) begin
            m_st = M_IDLE; m_wc = 0; m_hc = 0; m_ovrd = 1'b0; m_lcp = 2'b00;
            return;
        end
        nst = m_st;
        if (m_st == M_IDLE) m_lcp = lcp_cfg;
        case (m_st)
            M_IDLE: if (act_req) begin
                if (m_ovrd) nst = M_ACT;
                else begin nst = M_WAKE; m_wc = int'(WAKE_CYC); end
            end
            M_WAKE: begin
                m_wc = (m_wc > 0) ? m_wc - 1 : 0;
                if (m_wc == 0) nst = M_ACT;
            end
            M_ACT: if (!act_req) begin
                if (idle_hold == '0) nst = M_IDLE;
                else begin nst = M_HOLD; m_hc = int'(idle_hold); end
            end
            default: if (act_req) nst = M_ACT;
                else begin
                    m_hc = (m_hc > 0) ? m_hc - 1 : 0;
                    if (m_hc == 0) nst = M_IDLE;
                end
        endcase
        m_st   = nst;
        m_ovrd = ovrd_cfg;
    endtask

    // Drive one cycle: push the expectation, clock, capture outputs after the edge
    task automatic cyc(input logic r, input logic a, input logic [HOLD_W-1:0] ih,
                       input logic o, input logic [1:0] l);
        rst = r; act_req = a; idle_hold = ih; ovrd_cfg = o; lcp_cfg = l;
        model_step();
        sb_q.push_back(model_obs());
        @(posedge clk);
        #1;
        obs_q.push_back(dut_obs());
    endtask

    task automatic test_reset();
        logic [6:0] e, g;
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 2'b00);
        cyc(1'b1, 1'b1, 4'd3, 1'b1, 2'b11);
        n_checks++;
        if (dut_obs() !== 7'b0) $display("FAIL reset_vals: got %b want %b", dut_obs(), 7'b0);
        else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL reset_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_wake();
        logic [6:0] e, g;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_IDLE || rpen !== 1'b0) $display("FAIL wake_idle: got st=%b rpen=%b want st=00 rpen=0", st, rpen);
        else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_WAKE || rpen !== 1'b1 || act_rdy !== 1'b0)
            $display("FAIL wake_n1: got st=%b rpen=%b rdy=%b want 01 1 0", st, rpen, act_rdy);
        else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_WAKE || act_rdy !== 1'b0) $display("FAIL wake_n2: got st=%b rdy=%b want 01 0", st, act_rdy);
        else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_ACT || act_rdy !== 1'b1 || rpen !== 1'b1)
            $display("FAIL wake_n3: got st=%b rdy=%b rpen=%b want 10 1 1", st, act_rdy, rpen);
        else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL wake_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    // From ACTIVE: IdleHold=3 gives three HOLD cycles; IdleHold changes during HOLD are ignored
    task automatic test_hold();
        logic [6:0] e, g;
        cyc(1'b0, 1'b0, 4'd3, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 4'd9, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_HOLD || act_rdy !== 1'b1) $display("FAIL hold_third: got st=%b rdy=%b want 11 1", st, act_rdy);
        else n_pass++;
        cyc(1'b0, 1'b0, 4'd9, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_IDLE || rpen !== 1'b0 || act_rdy !== 1'b0)
            $display("FAIL hold_end: got st=%b rpen=%b rdy=%b want 00 0 0", st, rpen, act_rdy);
        else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL hold_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_hold_reassert();
        logic [6:0] e, g;
        logic       rdy_drop;
        repeat (3) cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        rdy_drop = 1'b0;
        cyc(1'b0, 1'b0, 4'd3, 1'b0, 2'b00);
        if (act_rdy !== 1'b1 || rpen !== 1'b1) rdy_drop = 1'b1;
        cyc(1'b0, 1'b0, 4'd3, 1'b0, 2'b00);
        if (act_rdy !== 1'b1 || rpen !== 1'b1) rdy_drop = 1'b1;
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 2'b00);
        if (act_rdy !== 1'b1 || rpen !== 1'b1) rdy_drop = 1'b1;
        n_checks++;
        if (st !== M_ACT) $display("FAIL reassert_st: got %b want 10", st); else n_pass++;
        n_checks++;
        if (rdy_drop !== 1'b0) $display("FAIL reassert_rdy: got drop=%b want 0", rdy_drop); else n_pass++;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_IDLE) $display("FAIL reassert_exit: got %b want 00", st); else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL reassert_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_override();
        logic [6:0] e, g;
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b00);
        n_checks++;
        if (rpovrd !== 1'b1 || st !== M_IDLE) $display("FAIL ovrd_idle: got ovrd=%b st=%b want 1 00", rpovrd, st);
        else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 2'b00);
        n_checks++;
        if (st !== M_ACT || act_rdy !== 1'b1 || rpovrd !== 1'b1)
            $display("FAIL ovrd_direct: got st=%b rdy=%b ovrd=%b want 10 1 1", st, act_rdy, rpovrd);
        else n_pass++;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (rpovrd !== 1'b0 || st !== M_IDLE) $display("FAIL ovrd_release: got ovrd=%b st=%b want 0 00", rpovrd, st);
        else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL ovrd_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_lcp();
        logic [6:0] e, g;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b11);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b11);
        n_checks++;
        if ({fd, rd} !== 2'b00 || st !== M_ACT) $display("FAIL lcp_frozen: got fd_rd=%b st=%b want 00 10", {fd, rd}, st);
        else n_pass++;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b11);
        n_checks++;
        if ({fd, rd} !== 2'b00 || st !== M_IDLE) $display("FAIL lcp_exit: got fd_rd=%b st=%b want 00 00", {fd, rd}, st);
        else n_pass++;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b11);
        n_checks++;
        if ({fd, rd} !== 2'b11) $display("FAIL lcp_load: got %b want 11", {fd, rd}); else n_pass++;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL lcp_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_wake();
        logic [6:0] e, g;
        logic       rdy_seen;
        rdy_seen = 1'b0;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        if (act_rdy !== 1'b0) rdy_seen = 1'b1;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        if (act_rdy !== 1'b0) rdy_seen = 1'b1;
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 2'b00);
        if (act_rdy !== 1'b0) rdy_seen = 1'b1;
        n_checks++;
        if (st !== M_IDLE || rpen !== 1'b0) $display("FAIL midwake_rst: got st=%b rpen=%b want 00 0", st, rpen);
        else n_pass++;
        n_checks++;
        if (rdy_seen !== 1'b0) $display("FAIL midwake_rdy: got seen=%b want 0", rdy_seen); else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_WAKE) $display("FAIL post_rst_req: got %b want 01", st); else n_pass++;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL midwake_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    // ActReq drops mid-wake: wake still completes, then IdleHold=1 gives one HOLD cycle
    task automatic test_wake_drop();
        logic [6:0] e, g;
        logic [7:0] seq;
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00); seq[7:6] = st;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00); seq[5:4] = st;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b00); seq[3:2] = st;
        cyc(1'b0, 1'b0, 4'd1, 1'b0, 2'b00); seq[1:0] = st;
        n_checks++;
        if (seq !== 8'b01_01_10_11) $display("FAIL wake_drop_seq: got %b want 01011011", seq); else n_pass++;
        cyc(1'b0, 1'b0, 4'd1, 1'b0, 2'b00);
        n_checks++;
        if (st !== M_IDLE) $display("FAIL hold_one: got %b want 00", st); else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL wake_drop_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [6:0] e, g;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                HOLD_W'($urandom_range(0, 4)),
                ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)));
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); g = obs_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL random_sb: got %b want %b", g, e); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; act_req = 1'b0; idle_hold = '0; ovrd_cfg = 1'b0; lcp_cfg = 2'b00;
        test_reset();
        test_wake();
        test_hold();
        test_hold_reassert();
        test_override();
        test_lcp();
        test_reset_mid_wake();
        test_wake_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl.md
ARF038B128E1R1W0CBBEHRAA4ACW_RCB_PWR_CTL -- requirements
Module: arf038b128e1r1w0cbbehraa4acw_rcb_pwr_ctl

Interface
- REQ-001: Parameter WAKE_CYC, default 2: clock-tree settle cycles from RPEn rise to ActRdy rise; legal range 1..15.
- REQ-002: Parameter HOLD_W, default 4: width of the idle-hold count.
- REQ-003: CkGridX1N  input  1  grid clock; all state updates on its rising edge.
- REQ-004: Rst  input  1  synchronous, active-high reset.
- REQ-005: ActReq  input  1  activity request (read/write pending) from array control.
- REQ-006: IdleHold  input  HOLD_W  idle cycles to keep the clock running after ActReq drops.
- REQ-007: OvrdCfg  input  1  software power override request.
- REQ-008: LcpCfg  input  2  LCP configuration {Fd,Rd}.
- REQ-009: RPEn  output  1  regional power enable to RCB (1 = functional).
- REQ-010: RPOvrd  output  1  regional power override to RCB.
- REQ-011: Fd, Rd  output  1 each  LCP bits to RCB.
- REQ-012: ActRdy  output  1  regional clock running and settled; requester may issue accesses.
- REQ-013: St  output  2  FSM state for debug.

Function
- REQ-014: The FSM SHALL have four states encoded on St: IDLE=00, WAKE=01, ACTIVE=10, HOLD=11.
- REQ-015: All outputs SHALL be registered; RPEn=1 in WAKE, ACTIVE and HOLD, 0 in IDLE.
- REQ-016: ActRdy SHALL be 1 in ACTIVE and HOLD only.
- REQ-017: IDLE with ActReq=1 and RPOvrd=0 SHALL go to WAKE, loading the wake counter with WAKE_CYC.
- REQ-018: IDLE with ActReq=1 and RPOvrd=1 SHALL go directly to ACTIVE (clock already running, no settle).
- REQ-019: WAKE SHALL decrement the wake counter each cycle and go to ACTIVE when it reaches 1; ActReq sampled high at edge N gives RPEn=1 from N+1 and ActRdy=1 from N+1+WAKE_CYC.
- REQ-020: WAKE SHALL always complete, including when ActReq drops mid-wake; the drop is evaluated once in ACTIVE.
- REQ-021: ACTIVE with ActReq=0 SHALL go to IDLE when IdleHold=0, else to HOLD, loading the hold counter with IdleHold.
- REQ-022: HOLD with ActReq=1 SHALL return to ACTIVE on the next edge with no wake latency; ActRdy stays 1.
- REQ-023: HOLD with ActReq=0 SHALL decrement the hold counter and go to IDLE when it is 1, giving exactly IdleHold HOLD cycles.
- REQ-024: IdleHold SHALL be sampled only on the ACTIVE->HOLD transition; changes during HOLD are ignored.
- REQ-025: RPOvrd SHALL equal OvrdCfg delayed one cycle, independent of FSM state; it SHALL not force a state change.
- REQ-026: Fd/Rd SHALL load from LcpCfg only in cycles where St=IDLE, and hold otherwise, so LCP never changes while the clock is enabled.
- REQ-027: Counters SHALL saturate at 0 and never wrap.

Reset
- REQ-028: Rst=1 at an edge SHALL set St=IDLE, RPEn=0, RPOvrd=0, ActRdy=0, Fd=0, Rd=0, and both counters to 0, overriding all other inputs.
- REQ-029: Rst asserted in any state SHALL yield the reset values on the following cycle; no wake or hold completes.
- REQ-030: ActReq=1 on the first edge after Rst deasserts SHALL be honoured per REQ-017/018.

Verification
- REQ-031: WAKE_CYC=2, OvrdCfg=0, ActReq rises at edge 10 -> RPEn=1 at cycle 11, ActRdy=1 at cycle 13, St sequence 00,01,01,10.
- REQ-032: ACTIVE, IdleHold=3, ActReq falls at edge 20 -> St=HOLD for cycles 21-23, IDLE at cycle 24 with RPEn=0 and ActRdy=0.
- REQ-033: HOLD with counter=2, ActReq re-asserts -> St=ACTIVE next cycle, ActRdy held at 1 throughout, RPEn never drops.
- REQ-034: OvrdCfg=1 for 2 cycles, then ActReq=1 in IDLE -> RPOvrd=1, St goes 00->10 directly, ActRdy=1 one cycle after the request.
- REQ-035: LcpCfg changes 00->11 during ACTIVE -> Fd/Rd stay 00; after return to IDLE, Fd=Rd=1 on the next cycle.
- REQ-036: Rst pulsed during WAKE with counter=1 -> next cycle St=IDLE, RPEn=0, ActRdy never asserts.
